// File: rtl/axi_cmd_pkg.sv
// Shared request type, FSM state and AXI response/burst constants for the command front end.
package axi_cmd_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int NAT_ADDR_W = 26;
  localparam int BEAT_SHIFT = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [NAT_ADDR_W-1:0] addr;
    logic [1:0]            burst;
    logic [7:0]            len;
    logic [3:0]            size;
    logic                  id;
  } axi_req_t;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  // WRAP is deliberately walked like INCR; only FIXED keeps the base address.
  function automatic logic addr_steps(input logic [1:0] burst);
    case (burst)
      BURST_FIXED:            return 1'b0;
      BURST_INCR, BURST_WRAP: return 1'b1;
      default:                return 1'b1;
    endcase
  endfunction

  function automatic logic req_bad(input axi_req_t r);
    return (r.size != 4'd5) || (r.burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_cmd_bq.sv
// Synchronous FIFO for B responses; push and pop are same-cycle, output reads the head entry combinationally.
// A push while full is accepted only when a pop happens in the same cycle (count stays put).
module axi_cmd_bq
  import axi_cmd_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/axi_cmd_front.sv
// AXI AW/AR/B front end splitting bursts into single-beat native commands; AXI_ERR_CHECK_EN enables size/burst rejection.
// First beat follows the accept by one grant cycle; cmd_* hold under cmd_ready backpressure, writes wait while the B queue is full.
module axi_cmd_front
  import axi_cmd_pkg::*;
#(
  parameter int ADDR_W   = AXI_ADDR_W,
  parameter int NAT_AW   = NAT_ADDR_W,
  parameter int BQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [1:0]        aw_burst,
  input  logic [7:0]        aw_len,
  input  logic [3:0]        aw_size,
  input  logic              aw_id,
  input  logic [1:0]        aw_lock,
  input  logic [2:0]        aw_prot,
  input  logic [3:0]        aw_cache,
  input  logic [3:0]        aw_qos,
  input  logic              aw_first,
  input  logic              aw_last,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [1:0]        ar_burst,
  input  logic [7:0]        ar_len,
  input  logic [3:0]        ar_size,
  input  logic              ar_id,
  input  logic [1:0]        ar_lock,
  input  logic [2:0]        ar_prot,
  input  logic [3:0]        ar_cache,
  input  logic [3:0]        ar_qos,
  input  logic              ar_first,
  input  logic              ar_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [1:0]        b_resp,
  output logic              b_id,
  output logic              b_first,
  output logic              b_last,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [NAT_AW-1:0] cmd_addr,
  output logic              cmd_last,
  output logic              ar_err
);

  axi_req_t          aw_q;
  axi_req_t          ar_q;
  axi_req_t          sel_req;
  logic              aw_held;
  logic              ar_held;
  state_t            state;
  logic              last_grant_wr;
  logic [7:0]        beat;
  logic [7:0]        cur_len;
  logic [NAT_AW-1:0] cur_base;
  logic              cur_incr;
  logic              cur_id;

  logic              wr_ok;
  logic              grant_rd;
  logic              grant_wr;
  logic              rd_bad;
  logic              wr_bad;
  logic              sel_bad;
  logic              cmd_fire;
  logic              bq_push;
  logic              bq_pop;
  logic              bq_full;
  logic              bq_empty;
  logic [2:0]        bq_din;
  logic [2:0]        bq_dout;

  assign aw_ready = !aw_held;
  assign ar_ready = !ar_held;
  assign cmd_fire = cmd_valid && cmd_ready;

  // Round-robin between held requests; a blocked write (B queue full) yields to a read.
  assign wr_ok    = aw_held && !bq_full;
  assign grant_rd = (state == ST_IDLE) && ar_held && (!wr_ok || last_grant_wr);
  assign grant_wr = (state == ST_IDLE) && wr_ok && !grant_rd;
  assign sel_req  = grant_rd ? ar_q : aw_q;
  assign sel_bad  = grant_rd ? rd_bad : wr_bad;

`ifdef AXI_ERR_CHECK_EN
  assign rd_bad = req_bad(ar_q);
  assign wr_bad = req_bad(aw_q);
`else
  assign rd_bad = 1'b0;
  assign wr_bad = 1'b0;
`endif

  always_comb begin
    bq_push = 1'b0;
    bq_din  = {cur_id, RESP_OKAY};
    if (grant_wr && wr_bad) begin
      bq_push = 1'b1;
      bq_din  = {aw_q.id, RESP_SLVERR};
    end else if ((state == ST_BURST) && cmd_fire && cmd_last && cmd_we) begin
      bq_push = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held       <= 1'b0;
      ar_held       <= 1'b0;
      aw_q          <= '0;
      ar_q          <= '0;
      state         <= ST_IDLE;
      last_grant_wr <= 1'b1;
      beat          <= '0;
      cur_len       <= '0;
      cur_base      <= '0;
      cur_incr      <= 1'b0;
      cur_id        <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_we        <= 1'b0;
      cmd_addr      <= '0;
      cmd_last      <= 1'b0;
      ar_err        <= 1'b0;
    end else begin
      ar_err <= 1'b0;
      if (aw_valid && aw_ready) begin
        aw_held <= 1'b1;
        aw_q    <= '{addr: aw_addr[NAT_AW+BEAT_SHIFT-1:BEAT_SHIFT], burst: aw_burst,
                     len: aw_len, size: aw_size, id: aw_id};
      end
      if (ar_valid && ar_ready) begin
        ar_held <= 1'b1;
        ar_q    <= '{addr: ar_addr[NAT_AW+BEAT_SHIFT-1:BEAT_SHIFT], burst: ar_burst,
                     len: ar_len, size: ar_size, id: ar_id};
      end
      case (state)
        ST_IDLE: begin
          if (grant_rd || grant_wr) begin
            last_grant_wr <= grant_wr;
            if (sel_bad) begin
              // Rejected requests never reach BURST; they just free their slot.
              if (grant_wr) begin
                aw_held <= 1'b0;
              end else begin
                ar_held <= 1'b0;
                ar_err  <= 1'b1;
              end
            end else begin
              state     <= ST_BURST;
              cmd_valid <= 1'b1;
              cmd_we    <= grant_wr;
              cmd_addr  <= sel_req.addr;
              cmd_last  <= (sel_req.len == 8'd0);
              beat      <= '0;
              cur_base  <= sel_req.addr;
              cur_len   <= sel_req.len;
              cur_incr  <= addr_steps(sel_req.burst);
              cur_id    <= sel_req.id;
            end
          end
        end
        ST_BURST: begin
          if (cmd_fire) begin
            if (cmd_last) begin
              state     <= ST_IDLE;
              cmd_valid <= 1'b0;
              cmd_we    <= 1'b0;
              cmd_last  <= 1'b0;
              if (cmd_we) aw_held <= 1'b0;
              else        ar_held <= 1'b0;
            end else begin
              beat     <= beat + 8'd1;
              cmd_last <= ((beat + 8'd1) == cur_len);
              cmd_addr <= cur_incr ? cur_base + NAT_AW'(beat + 8'd1) : cur_base;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bq_pop = b_valid && b_ready;

  axi_cmd_bq #(
    .W     (3),
    .DEPTH (BQ_DEPTH)
  ) u_bq (
    .clk   (clk),
    .rst   (rst),
    .push  (bq_push),
    .din   (bq_din),
    .pop   (bq_pop),
    .dout  (bq_dout),
    .empty (bq_empty),
    .full  (bq_full)
  );

  assign b_valid = !bq_empty;
  assign b_id    = bq_dout[2];
  assign b_resp  = bq_dout[1:0];
  assign b_first = b_valid;
  assign b_last  = b_valid;

  logic unused_ok;
  assign unused_ok = ^{aw_addr, aw_lock, aw_prot, aw_cache, aw_qos, aw_first, aw_last,
                       ar_addr, ar_lock, ar_prot, ar_cache, ar_qos, ar_first, ar_last,
                       sel_req.size};

endmodule

// File: tb/tb_axi_cmd_front.sv
// Directed bench for axi_cmd_front: expected beats and B responses are queued at drive time and popped by monitors.
`timescale 1ns/1ps
module tb_axi_cmd_front;
  import axi_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        aw_valid, aw_ready, aw_id, aw_first, aw_last;
  logic [31:0] aw_addr;
  logic [1:0]  aw_burst, aw_lock;
  logic [7:0]  aw_len;
  logic [3:0]  aw_size, aw_cache, aw_qos;
  logic [2:0]  aw_prot;
  logic        ar_valid, ar_ready, ar_id, ar_first, ar_last;
  logic [31:0] ar_addr;
  logic [1:0]  ar_burst, ar_lock;
  logic [7:0]  ar_len;
  logic [3:0]  ar_size, ar_cache, ar_qos;
  logic [2:0]  ar_prot;
  logic        b_valid, b_ready, b_id, b_first, b_last;
  logic [1:0]  b_resp;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_last, ar_err;
  logic [25:0] cmd_addr;

  always #5 clk = ~clk;

  axi_cmd_front dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_burst(aw_burst),
    .aw_len(aw_len), .aw_size(aw_size), .aw_id(aw_id), .aw_lock(aw_lock), .aw_prot(aw_prot),
    .aw_cache(aw_cache), .aw_qos(aw_qos), .aw_first(aw_first), .aw_last(aw_last),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_burst(ar_burst),
    .ar_len(ar_len), .ar_size(ar_size), .ar_id(ar_id), .ar_lock(ar_lock), .ar_prot(ar_prot),
    .ar_cache(ar_cache), .ar_qos(ar_qos), .ar_first(ar_first), .ar_last(ar_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
    .b_first(b_first), .b_last(b_last),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_last(cmd_last), .ar_err(ar_err)
  );

  typedef struct packed {
    logic        we;
    logic        last;
    logic [25:0] addr;
  } exp_cmd_t;

  exp_cmd_t   exp_cmd[$];
  logic [2:0] exp_b[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound(input string tag, input logic ok);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed=timeout expected=event within budget", tag);
    end
  endtask

  function automatic void exp_burst(input logic we, input logic [31:0] a,
                                    input logic [7:0] l, input logic [1:0] b);
    logic [25:0] base;
    exp_cmd_t    e;
    base = a[30:5];
    for (int i = 0; i <= int'(l); i++) begin
      e.we   = we;
      e.last = (i == int'(l));
      e.addr = (b == BURST_FIXED) ? base : base + 26'(i);
      exp_cmd.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_cmd_t e;
    if (cmd_valid && cmd_ready) begin
      checks++;
      assert (exp_cmd.size() != 0) else begin
        errors++;
        $error("FAIL cmd_extra: observed beat addr=%0h we=%0b, expected no beat", cmd_addr, cmd_we);
      end
      if (exp_cmd.size() != 0) begin
        e = exp_cmd.pop_front();
        chk("cmd_beat{we,last,addr}", {4'd0, cmd_we, cmd_last, cmd_addr}, {4'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] eb;
    if (b_valid && b_ready) begin
      checks++;
      assert (exp_b.size() != 0) else begin
        errors++;
        $error("FAIL b_extra: observed id=%0b resp=%0b, expected no response", b_id, b_resp);
      end
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        chk("b_rsp{id,resp}", {29'd0, b_id, b_resp}, {29'd0, eb});
        chk("b_first_last", {30'd0, b_first, b_last}, 32'd3);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cmd.delete();
    exp_b.delete();
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic aw_xfer(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [3:0] s, input logic id);
    int n = 0;
    aw_addr = a; aw_len = l; aw_burst = b; aw_size = s; aw_id = id; aw_valid = 1'b1;
    @(negedge clk);
    while (!aw_ready && n < 100) begin @(negedge clk); n++; end
    bound("aw_accept", n < 100);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic ar_xfer(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [3:0] s, input logic id);
    int n = 0;
    ar_addr = a; ar_len = l; ar_burst = b; ar_size = s; ar_id = id; ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && n < 100) begin @(negedge clk); n++; end
    bound("ar_accept", n < 100);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_b.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    cyc(5);
    bound(tag, (exp_cmd.size() == 0) && (exp_b.size() == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    rst = 1'b0;
    aw_valid = 0; aw_addr = 0; aw_burst = 0; aw_len = 0; aw_size = 0; aw_id = 0;
    aw_lock = 0; aw_prot = 0; aw_cache = 0; aw_qos = 0; aw_first = 0; aw_last = 0;
    ar_valid = 0; ar_addr = 0; ar_burst = 0; ar_len = 0; ar_size = 0; ar_id = 0;
    ar_lock = 0; ar_prot = 0; ar_cache = 0; ar_qos = 0; ar_first = 0; ar_last = 0;
    b_ready = 1'b1;
    cmd_ready = 1'b1;
    #12;
    chk("rst_aw_ready", 32'(aw_ready), 32'd1);
    chk("rst_ar_ready", 32'(ar_ready), 32'd1);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_we", 32'(cmd_we), 32'd0);
    chk("rst_cmd_last", 32'(cmd_last), 32'd0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst_ar_err", 32'(ar_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(2);

    // 1: INCR write, beats 2..5, then OKAY response with id 1
    exp_burst(1'b1, 32'h40, 8'd3, BURST_INCR);
    exp_b.push_back({1'b1, RESP_OKAY});
    aw_xfer(32'h40, 8'd3, BURST_INCR, 4'd5, 1'b1);
    drain("t1_drain");

    // 2: FIXED read stalled by cmd_ready
    cmd_ready = 1'b0;
    exp_burst(1'b0, 32'h100, 8'd1, BURST_FIXED);
    ar_xfer(32'h100, 8'd1, BURST_FIXED, 4'd5, 1'b0);
    n = 0;
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    bound("t2_cmd_valid", cmd_valid);
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", 32'(cmd_valid), 32'd1);
      chk("t2_stall_addr", 32'(cmd_addr), 32'd8);
      chk("t2_stall_we", 32'(cmd_we), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    drain("t2_drain");

    // 3: simultaneous AW/AR right after reset -> read first
    do_reset();
    exp_burst(1'b0, 32'h200, 8'd1, BURST_INCR);
    exp_burst(1'b1, 32'h300, 8'd1, BURST_INCR);
    exp_b.push_back({1'b0, RESP_OKAY});
    aw_addr = 32'h300; aw_len = 8'd1; aw_burst = BURST_INCR; aw_size = 4'd5; aw_id = 1'b0;
    ar_addr = 32'h200; ar_len = 8'd1; ar_burst = BURST_INCR; ar_size = 4'd5; ar_id = 1'b1;
    aw_valid = 1'b1; ar_valid = 1'b1;
    @(negedge clk);
    bound("t3_both_ready", aw_ready && ar_ready);
    @(posedge clk); #1;
    aw_valid = 1'b0; ar_valid = 1'b0;
    drain("t3_drain");

    // 4: B queue fills, third write held until responses drain
    b_ready = 1'b0;
    exp_burst(1'b1, 32'h400, 8'd0, BURST_INCR); exp_b.push_back({1'b1, RESP_OKAY});
    exp_burst(1'b1, 32'h420, 8'd0, BURST_INCR); exp_b.push_back({1'b0, RESP_OKAY});
    exp_burst(1'b1, 32'h440, 8'd0, BURST_INCR); exp_b.push_back({1'b1, RESP_OKAY});
    aw_xfer(32'h400, 8'd0, BURST_INCR, 4'd5, 1'b1);
    aw_xfer(32'h420, 8'd0, BURST_INCR, 4'd5, 1'b0);
    aw_xfer(32'h440, 8'd0, BURST_INCR, 4'd5, 1'b1);
    cyc(6);
    chk("t4_aw_ready_blocked", 32'(aw_ready), 32'd0);
    chk("t4_no_cmd", 32'(cmd_valid), 32'd0);
    chk("t4_b_valid", 32'(b_valid), 32'd1);
    b_ready = 1'b1;
    drain("t4_drain");

`ifdef AXI_ERR_CHECK_EN
    // 5: rejected write gets SLVERR, rejected read pulses ar_err
    exp_b.push_back({1'b1, RESP_SLVERR});
    aw_xfer(32'h500, 8'd0, BURST_INCR, 4'd2, 1'b1);
    drain("t5_wr_drain");
    ar_xfer(32'h600, 8'd0, 2'b11, 4'd5, 1'b0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin @(negedge clk); seen = ar_err; n++; end
    bound("t5_ar_err_pulse", seen);
    @(negedge clk);
    chk("t5_ar_err_one_cycle", 32'(ar_err), 32'd0);
    chk("t5_ar_ready_back", 32'(ar_ready), 32'd1);
    drain("t5_rd_drain");
`endif

    // 6: reset during beat 2 of a len-3 write
    exp_burst(1'b1, 32'h800, 8'd3, BURST_INCR);
    aw_xfer(32'h800, 8'd3, BURST_INCR, 4'd5, 1'b0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = cmd_valid && (cmd_addr == 26'd66);
      n++;
    end
    bound("t6_beat2", seen);
    #1;
    rst = 1'b0;
    #1;
    exp_cmd.delete();
    exp_b.delete();
    chk("t6_cmd_valid_drop", 32'(cmd_valid), 32'd0);
    chk("t6_b_valid_none", 32'(b_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_aw_ready_after", 32'(aw_ready), 32'd1);
    cyc(10);
    chk("t6_no_b_after", 32'(b_valid), 32'd0);
    chk("t6_no_cmd_after", 32'(cmd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
